reg_write_arbiter: RTL and testbench

Round-robin write arbiter and sequencer for a shared bank of level-sensitive D latches. It accepts write requests from N requesters and picks one winner per transaction. It sequences the bank's enable, data and clear lines so that data is stable around every enable pulse, then acknowledges the winner. It sits between client logic and a latch bank built from the existing D-latch cells.

---
 rtl/reg_write_arbiter_pkg.sv | 19 +
 rtl/reg_write_arbiter_rr_pick.sv | 32 +++
 rtl/reg_write_arbiter.sv | 124 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and defaults for the latch-bank write arbiter and its round-robin picker.
package reg_write_arbiter_pkg;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned DEF_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10,
    CLEAR = 2'b11
  } state_e;

  // Index width for an N-entry vector, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1, wrapping mod N.
module reg_write_arbiter_rr_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        win_idx  = idx;
        win[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter sequencing a level-sensitive latch bank: grant/data, one-cycle enable, then ack.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  input  logic           clr,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   ack,
  output logic           clr_ack,
  output logic [W-1:0]   latch_en,
  output logic [W-1:0]   latch_d,
  output logic           latch_clr,
  output logic           busy
);

  localparam int unsigned IW = idx_width(N);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          clr_ack_q, clr_ack_d;
  logic          latch_en_q, latch_en_d;
  logic [W-1:0]  latch_d_q, latch_d_d;
  logic          latch_clr_q, latch_clr_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  win;
  logic [IW-1:0] win_idx;
  logic          any;
  logic [W-1:0]  sel_data;

  reg_write_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  // Winner's data lane, selected by the one-hot win vector.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win[i]) sel_data = data_in[i*W +: W];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    latch_d_d   = latch_d_q;
    ack_d       = '0;
    clr_ack_d   = 1'b0;
    latch_en_d  = 1'b0;
    latch_clr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          state_d     = CLEAR;
          latch_clr_d = 1'b1;
          clr_ack_d   = 1'b1;
        end else if (any) begin
          state_d    = WRITE;
          grant_d    = win;
          latch_d_d  = sel_data;
          ptr_d      = win_idx;
          latch_en_d = 1'b1;
        end
      end
      WRITE: begin
        state_d = ACK;
        ack_d   = grant_q;
      end
      ACK: begin
        state_d = IDLE;
        grant_d = '0;
      end
      CLEAR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(N - 1);
      grant_q     <= '0;
      ack_q       <= '0;
      clr_ack_q   <= 1'b0;
      latch_en_q  <= 1'b0;
      latch_d_q   <= '0;
      latch_clr_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      clr_ack_q   <= clr_ack_d;
      latch_en_q  <= latch_en_d;
      latch_d_q   <= latch_d_d;
      latch_clr_q <= latch_clr_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign clr_ack   = clr_ack_q;
  assign latch_en  = {W{latch_en_q}};
  assign latch_d   = latch_d_q;
  assign latch_clr = latch_clr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (N=4, W=8).
module tb_reg_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        clr;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        clr_ack;
  logic [7:0]  latch_en;
  logic [7:0]  latch_d;
  logic        latch_clr;
  logic        busy;

  int n_checks;
  int n_fail;

  reg_write_arbiter #(.N(4), .W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .clr       (clr),
    .grant     (grant),
    .ack       (ack),
    .clr_ack   (clr_ack),
    .latch_en  (latch_en),
    .latch_d   (latch_d),
    .latch_clr (latch_clr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; clr = 1'b0; data_in = '0;
    tick(); tick();
    n_checks++;
    if ({grant, ack, clr_ack, latch_en, latch_d, latch_clr, busy} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b ack=%b clr_ack=%b en=%h d=%h clr=%b busy=%b required all zero",
               grant, ack, clr_ack, latch_en, latch_d, latch_clr, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_single_write();
    req = 4'b0001;
    data_in[7:0] = 8'hA5;
    tick();
    n_checks++;
    if (grant !== 4'b0001 || latch_d !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%b d=%h required 0001/a5", grant, latch_d);
    end
    n_checks++;
    if (latch_en !== 8'hFF || busy !== 1'b1 || ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_write_phase: got en=%h busy=%b ack=%b required ff/1/0000", latch_en, busy, ack);
    end
    tick();
    n_checks++;
    if (latch_en !== 8'h00 || ack !== 4'b0001 || grant !== 4'b0001 || latch_d !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_ack_phase: got en=%h ack=%b grant=%b d=%h required 00/0001/0001/a5",
               latch_en, ack, grant, latch_d);
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (ack !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000 || latch_d !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_idle: got ack=%b busy=%b grant=%b d=%h required 0000/0/0000/a5",
               ack, busy, grant, latch_d);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1111;
    data_in = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (grant !== exp_g[k] || latch_en !== 8'hFF) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got grant=%b en=%h required %b/ff", k, grant, latch_en, exp_g[k]);
      end
      tick();
      n_checks++;
      if (ack !== exp_g[k]) begin
        n_fail++;
        $display("FAIL rr_ack_%0d: got %b required %b", k, ack, exp_g[k]);
      end
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_clear_priority();
    clr = 1'b1;
    req = 4'b0100;
    tick();
    n_checks++;
    if (latch_clr !== 1'b1 || clr_ack !== 1'b1 || grant !== 4'b0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_phase: got clr=%b clr_ack=%b grant=%b busy=%b required 1/1/0000/1",
               latch_clr, clr_ack, grant, busy);
    end
    clr = 1'b0;
    tick();
    n_checks++;
    if (latch_clr !== 1'b0 || clr_ack !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_done: got clr=%b clr_ack=%b busy=%b required 0/0/0", latch_clr, clr_ack, busy);
    end
    tick();
    n_checks++;
    if (grant !== 4'b0100 || latch_d !== 8'h33) begin
      n_fail++;
      $display("FAIL clr_then_grant: got grant=%b d=%h required 0100/33", grant, latch_d);
    end
    tick();
    req = 4'b0000;
    tick();
  endtask

  task automatic test_data_hold();
    req = 4'b0010;
    data_in[15:8] = 8'h3C;
    tick();
    n_checks++;
    if (grant !== 4'b0010 || latch_d !== 8'h3C) begin
      n_fail++;
      $display("FAIL hold_grant: got grant=%b d=%h required 0010/3c", grant, latch_d);
    end
    data_in[15:8] = 8'hFF;
    tick();
    n_checks++;
    if (latch_d !== 8'h3C || ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL hold_ack: got d=%h ack=%b required 3c/0010", latch_d, ack);
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (latch_d !== 8'h3C) begin
      n_fail++;
      $display("FAIL hold_idle: got d=%h required 3c", latch_d);
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b0001;
    data_in[7:0] = 8'h11;
    tick();
    n_checks++;
    if (latch_en !== 8'hFF || grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_write: got en=%h grant=%b required ff/0001", latch_en, grant);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (latch_en !== 8'h00 || grant !== 4'b0000 || busy !== 1'b0 || latch_d !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_async_reset: got en=%h grant=%b busy=%b d=%h required 00/0000/0/00",
               latch_en, grant, busy, latch_d);
    end
    tick();
    n_checks++;
    if (ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_no_ack: got %b required 0000", ack);
    end
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1111;
    tick();
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_first_prio: got %b required 0001", grant);
    end
    tick();
    req = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    req = 4'b0010;
    tick();
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL b2b_first: got %b required 0010", grant);
    end
    tick();
    req = 4'b1010;
    tick();
    tick();
    n_checks++;
    if (grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL b2b_second: got %b required 1000", grant);
    end
    tick();
    n_checks++;
    if (ack !== 4'b1000) begin
      n_fail++;
      $display("FAIL b2b_second_ack: got %b required 1000", ack);
    end
    req = 4'b0010;
    tick();
    tick();
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL b2b_third: got %b required 0010", grant);
    end
    tick();
    req = 4'b0000;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got busy=%b required 0", busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_clear_priority();
    test_data_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
